// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared types, constants and MISR step for the adder result checker
// Contents: FSM state enum, MISR polynomial, counter/index/signature widths,
//           saturation and "no error" constants, one MISR step function.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    localparam int ERR_CNT_W = 16;
    localparam int IDX_W     = 32;
    localparam int SIG_W     = 32;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX    = '1;
    localparam logic [IDX_W-1:0]     FIRST_IDX_NONE = '1;

    // One MISR step: shift with polynomial feedback, then absorb the folded word.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] data);
        logic [SIG_W-1:0] shifted;
        shifted = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            shifted = shifted ^ MISR_POLY;
        end
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/chk_delay_line.sv
// rtl/chk_delay_line.sv - fixed-depth register pipeline used to align operands with DUT results
// Parameters: WIDTH (bits per stage), DEPTH (number of stages, >= 1)
// Ports: iClk  - clock
//        iRst  - synchronous active-high reset, clears every stage
//        iData - word entering the pipeline
//        oData - word that entered DEPTH edges earlier
module chk_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= iData;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign oData = stage_q[DEPTH-1];

endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - checks an adder DUT's sum/carry against a reference over a run of samples
// Optional feature: define CHECKER_MISR_EN to build the 32-bit MISR on oSignature;
//                   otherwise oSignature is tied to zero.
// Ports: iClk/iRst       - clock, synchronous active-high reset
//        iStart          - starts a run from IDLE or DONE (ignored in RUN)
//        iValid,iA,iB,iC - operands as presented to the DUT
//        iSum,iCarry     - DUT result, DUT_LATENCY cycles after the operands
//        oBusy/oDone     - in RUN / in DONE
//        oErrFlag        - sticky mismatch flag for the current run
//        oErrCnt         - saturating mismatch count
//        oFirstErrIdx    - index of the first mismatching sample, all ones if none
//        oSignature      - MISR over the checked DUT results
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int ADDER_WIDTH = 64,
    parameter int DUT_LATENCY = 1,
    parameter int NUM_SAMPLES = 1024
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic                   iValid,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iC,
    input  logic [ADDER_WIDTH-1:0] iSum,
    input  logic                   iCarry,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oErrFlag,
    output logic [ERR_CNT_W-1:0]   oErrCnt,
    output logic [IDX_W-1:0]       oFirstErrIdx,
    output logic [SIG_W-1:0]       oSignature
);

    localparam int              PIPE_W   = 2 * ADDER_WIDTH + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    // Operand alignment: valid, carry-in and both operands travel together.
    logic [PIPE_W-1:0] pipe_in;
    logic [PIPE_W-1:0] pipe_out;

    assign pipe_in = {iValid, iC, iA, iB};

    chk_delay_line #(
        .WIDTH (PIPE_W),
        .DEPTH (DUT_LATENCY)
    ) u_delay (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (pipe_in),
        .oData (pipe_out)
    );

    logic                   al_valid;
    logic                   al_c;
    logic [ADDER_WIDTH-1:0] al_a;
    logic [ADDER_WIDTH-1:0] al_b;
    logic [ADDER_WIDTH:0]   exp_res;
    logic                   mismatch;

    assign al_valid = pipe_out[PIPE_W-1];
    assign al_c     = pipe_out[PIPE_W-2];
    assign al_a     = pipe_out[2*ADDER_WIDTH-1:ADDER_WIDTH];
    assign al_b     = pipe_out[ADDER_WIDTH-1:0];

    // Reference result one bit wider than the operands so the MSB is the carry-out.
    assign exp_res  = {1'b0, al_a} + {1'b0, al_b} + {{ADDER_WIDTH{1'b0}}, al_c};
    assign mismatch = ({iCarry, iSum} != exp_res);

    chk_state_e           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 chk_vld_q, chk_vld_d;
    logic                 chk_mis_q, chk_mis_d;
    logic                 err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]     first_idx_q, first_idx_d;
    logic [IDX_W-1:0]     sample_idx_q, sample_idx_d;

`ifdef CHECKER_MISR_EN
    logic [ADDER_WIDTH:0] chk_word_q, chk_word_d;
    logic [SIG_W-1:0]     sig_q, sig_d;
    logic [SIG_W-1:0]     fold_word;

    // XOR of all 32-bit chunks of {carry,sum}; the top chunk is implicitly zero-padded.
    always_comb begin
        fold_word = '0;
        for (int i = 0; i <= ADDER_WIDTH; i++) begin
            fold_word[i % SIG_W] = fold_word[i % SIG_W] ^ chk_word_q[i];
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        err_flag_d   = err_flag_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        sample_idx_d = sample_idx_q;
        // Only aligned results seen while running are carried into the check stage,
        // so results arriving in IDLE/DONE never reach the counters.
        chk_vld_d    = al_valid && (state_q == RUN);
        chk_mis_d    = mismatch;
`ifdef CHECKER_MISR_EN
        chk_word_d   = {iCarry, iSum};
        sig_d        = sig_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d      = RUN;
                    err_flag_d   = 1'b0;
                    err_cnt_d    = '0;
                    first_idx_d  = FIRST_IDX_NONE;
                    sample_idx_d = '0;
`ifdef CHECKER_MISR_EN
                    sig_d        = '0;
`endif
                end
            end
            RUN: begin
                if (chk_vld_q) begin
                    sample_idx_d = sample_idx_q + 1'b1;
`ifdef CHECKER_MISR_EN
                    sig_d        = misr_step(sig_q, fold_word);
`endif
                    if (chk_mis_q) begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != ERR_CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (!err_flag_q) begin
                            first_idx_d = sample_idx_q;
                        end
                    end
                    // The last sample is scored on the same edge that leaves RUN.
                    if (sample_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            chk_vld_q    <= 1'b0;
            chk_mis_q    <= 1'b0;
            err_flag_q   <= 1'b0;
            err_cnt_q    <= '0;
            first_idx_q  <= FIRST_IDX_NONE;
            sample_idx_q <= '0;
`ifdef CHECKER_MISR_EN
            chk_word_q   <= '0;
            sig_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            chk_vld_q    <= chk_vld_d;
            chk_mis_q    <= chk_mis_d;
            err_flag_q   <= err_flag_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            sample_idx_q <= sample_idx_d;
`ifdef CHECKER_MISR_EN
            chk_word_q   <= chk_word_d;
            sig_q        <= sig_d;
`endif
        end
    end

    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oErrFlag     = err_flag_q;
    assign oErrCnt      = err_cnt_q;
    assign oFirstErrIdx = first_idx_q;
`ifdef CHECKER_MISR_EN
    assign oSignature   = sig_q;
`else
    assign oSignature   = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - directed self-checking bench for adder_result_checker
module tb_adder_result_checker;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] dut_sum;
    logic         dut_carry;

    logic        busy4, done4, flag4;
    logic [15:0] cnt4;
    logic [31:0] first4, sig4;
    logic        busy1, done1, flag1;
    logic [15:0] cnt1;
    logic [31:0] first1, sig1;
    logic        busys, dones, flags;
    logic [15:0] cnts;
    logic [31:0] firsts, sigs;

    int checks   = 0;
    int failures = 0;

    logic [W:0]  pend;
    logic [31:0] exp_sig;

    always #5 clk = ~clk;

    adder_result_checker #(.ADDER_WIDTH(W), .DUT_LATENCY(1), .NUM_SAMPLES(4)) u_dut4 (
        .iClk(clk), .iRst(rst), .iStart(start), .iValid(valid), .iA(a), .iB(b), .iC(c_in),
        .iSum(dut_sum), .iCarry(dut_carry), .oBusy(busy4), .oDone(done4), .oErrFlag(flag4),
        .oErrCnt(cnt4), .oFirstErrIdx(first4), .oSignature(sig4));

    adder_result_checker #(.ADDER_WIDTH(W), .DUT_LATENCY(1), .NUM_SAMPLES(1)) u_dut1 (
        .iClk(clk), .iRst(rst), .iStart(start), .iValid(valid), .iA(a), .iB(b), .iC(c_in),
        .iSum(dut_sum), .iCarry(dut_carry), .oBusy(busy1), .oDone(done1), .oErrFlag(flag1),
        .oErrCnt(cnt1), .oFirstErrIdx(first1), .oSignature(sig1));

    adder_result_checker #(.ADDER_WIDTH(W), .DUT_LATENCY(1), .NUM_SAMPLES(70000)) u_duts (
        .iClk(clk), .iRst(rst), .iStart(start), .iValid(valid), .iA(a), .iB(b), .iC(c_in),
        .iSum(dut_sum), .iCarry(dut_carry), .oBusy(busys), .oDone(dones), .oErrFlag(flags),
        .oErrCnt(cnts), .oFirstErrIdx(firsts), .oSignature(sigs));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of emulated adder DUT: present last cycle's result, drive new operands.
    task automatic cyc(input logic v, input logic [W-1:0] opa, input logic [W-1:0] opb,
                       input logic opc, input logic flip_sum, input logic flip_carry);
        logic [W:0] r;
        {dut_carry, dut_sum} = pend;
        valid = v;
        a     = opa;
        b     = opb;
        c_in  = opc;
        r     = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, opc};
        r[0]  = r[0] ^ flip_sum;
        r[W]  = r[W] ^ flip_carry;
        pend  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    initial begin
`ifdef CHECKER_MISR_EN
        exp_sig = 32'h0000_0001;
`else
        exp_sig = 32'h0000_0000;
`endif
        rst   = 1'b1;
        start = 1'b0;
        pend  = '0;
        idle(2);
        check("rst_busy",  {63'd0, busy4}, 64'd0);
        check("rst_done",  {63'd0, done4}, 64'd0);
        check("rst_flag",  {63'd0, flag4}, 64'd0);
        check("rst_cnt",   {48'd0, cnt4}, 64'd0);
        check("rst_first", {32'd0, first4}, 64'hFFFF_FFFF);
        check("rst_sig",   {32'd0, sig4}, 64'd0);
        rst = 1'b0;

        // Clean run of 4 samples: done lands 6 edges after the start edge.
        pulse_start();
        check("r1_busy", {63'd0, busy4}, 64'd1);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 64'(i + 1) * 64'h1111_1111_1111_1111, 64'hFFFF_0000_FFFF_0000, 1'(i), 1'b0, 1'b0);
        idle(1);
        check("r1_done_edge5", {63'd0, done4}, 64'd0);
        idle(1);
        check("r1_done_edge6", {63'd0, done4}, 64'd1);
        check("r1_busy_end",   {63'd0, busy4}, 64'd0);
        check("r1_cnt",        {48'd0, cnt4}, 64'd0);
        check("r1_flag",       {63'd0, flag4}, 64'd0);
        check("r1_first",      {32'd0, first4}, 64'hFFFF_FFFF);

        // Sum bit0 flipped on sample 2 only.
        pulse_start();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 64'hDEAD_BEEF_0000_0000 + 64'(i), 64'h8000_0000_0000_0001, 1'b1, 1'(i == 2), 1'b0);
        check("r2_flag_before", {63'd0, flag4}, 64'd0);
        idle(1);
        check("r2_flag_after",  {63'd0, flag4}, 64'd1);
        check("r2_done_edge5",  {63'd0, done4}, 64'd0);
        idle(1);
        check("r2_done", {63'd0, done4}, 64'd1);
        check("r2_cnt",  {48'd0, cnt4}, 64'd1);
        check("r2_first", {32'd0, first4}, 64'd2);

        // All-ones operands with carry-in, DUT drops the carry-out; iStart mid-run ignored.
        pulse_start();
        cyc(1'b1, '1, '1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 64'd5, 64'd7, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, '1, 64'd1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc(1'b1, 64'd100, 64'd200, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        idle(2);
        check("r3_done",  {63'd0, done4}, 64'd1);
        check("r3_cnt",   {48'd0, cnt4}, 64'd1);
        check("r3_flag",  {63'd0, flag4}, 64'd1);
        check("r3_first", {32'd0, first4}, 64'd0);

        // Reset mid-run (with iStart asserted) after two samples, then a clean rerun.
        pulse_start();
        cyc(1'b1, 64'd3, 64'd4, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'd9, 64'd9, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("r4_cnt_mid", {48'd0, cnt4}, 64'd2);
        rst   = 1'b1;
        start = 1'b1;
        idle(1);
        rst   = 1'b0;
        start = 1'b0;
        check("r4_rst_busy",  {63'd0, busy4}, 64'd0);
        check("r4_rst_done",  {63'd0, done4}, 64'd0);
        check("r4_rst_flag",  {63'd0, flag4}, 64'd0);
        check("r4_rst_cnt",   {48'd0, cnt4}, 64'd0);
        check("r4_rst_first", {32'd0, first4}, 64'hFFFF_FFFF);
        check("r4_rst_sig",   {32'd0, sig4}, 64'd0);
        pulse_start();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 64'(i) << 60, 1'(i), 1'b0, 1'b0);
        idle(2);
        check("r4_rerun_done",  {63'd0, done4}, 64'd1);
        check("r4_rerun_cnt",   {48'd0, cnt4}, 64'd0);
        check("r4_rerun_first", {32'd0, first4}, 64'hFFFF_FFFF);

        // Single-sample run, A=1 B=0 C=0: signature is 1 with the MISR, 0 without.
        pulse_start();
        cyc(1'b1, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("r5_done1", {63'd0, done1}, 64'd1);
        check("r5_cnt1",  {48'd0, cnt1}, 64'd0);
        check("r5_sig1",  {32'd0, sig1}, {32'd0, exp_sig});

        // 70000 wrong samples: count saturates, first error at index 0.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 70000; i++)
            cyc(1'b1, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("r6_done_early", {63'd0, dones}, 64'd0);
        idle(1);
        check("r6_done",  {63'd0, dones}, 64'd1);
        check("r6_cnt",   {48'd0, cnts}, 64'hFFFF);
        check("r6_flag",  {63'd0, flags}, 64'd1);
        check("r6_first", {32'd0, firsts}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 64, operand/sum width.
REQ-002 SHALL have parameter DUT_LATENCY, default 1, cycles from operand sample to DUT result (range 1..8).
REQ-003 SHALL have parameter NUM_SAMPLES, default 1024, valid samples checked per run (>=1).
REQ-004 iClk  input  1  sole clock, all state on rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iStart  input  1  one-cycle pulse; starts a run from IDLE or DONE.
REQ-007 iValid  input  1  operands iA/iB/iC valid this cycle.
REQ-008 iA, iB  input  ADDER_WIDTH each  operands as driven to the DUT.
REQ-009 iC  input  1  carry-in as driven to the DUT.
REQ-010 iSum  input  ADDER_WIDTH  DUT sum, valid DUT_LATENCY cycles after iValid.
REQ-011 iCarry  input  1  DUT carry-out, same timing as iSum.
REQ-012 oBusy  output  1  high in RUN.
REQ-013 oDone  output  1  high in DONE.
REQ-014 oErrFlag  output  1  sticky: at least one mismatch this run.
REQ-015 oErrCnt  output  16  mismatch count, saturating at 16'hFFFF.
REQ-016 oFirstErrIdx  output  32  sample index (0-based) of first mismatch; 32'hFFFFFFFF if none.
REQ-017 oSignature  output  32  MISR signature of checked sums (see Configuration).

Function
REQ-018 SHALL implement FSM IDLE -> RUN on iStart; RUN -> DONE when checked count reaches NUM_SAMPLES; DONE -> RUN on iStart; DONE otherwise holds.
REQ-019 iStart in RUN SHALL be ignored.
REQ-020 Entering RUN SHALL clear oErrFlag, oErrCnt, sample index, oSignature and set oFirstErrIdx to all ones, in the same edge.
REQ-021 SHALL delay iValid/iA/iB/iC through a DUT_LATENCY-deep register pipeline, aligning them with iSum/iCarry.
REQ-022 Expected result SHALL be {carry,sum} = iA + iB + iC, computed at ADDER_WIDTH+1 bits, carry = MSB.
REQ-023 A check SHALL occur in each RUN cycle where the aligned valid is high; mismatch = sum or carry differs.
REQ-024 Check outcome SHALL be registered: counters/flags update one edge after aligned result (total latency DUT_LATENCY+1 from iValid).
REQ-025 Aligned valids arriving in IDLE or DONE SHALL be discarded; valids in flight at RUN->DONE transition SHALL be discarded.
REQ-026 Final check (index NUM_SAMPLES-1) and the RUN->DONE transition SHALL occur on the same edge; its result SHALL be reflected in outputs.
REQ-027 oFirstErrIdx SHALL be written only on first mismatch of a run.
REQ-028 Pipeline SHALL keep shifting in all states so alignment is preserved across iStart.

Reset
REQ-029 On iRst: state IDLE, pipeline valids 0, oBusy 0, oDone 0, oErrFlag 0, oErrCnt 0, oFirstErrIdx 32'hFFFFFFFF, oSignature 0.
REQ-030 iRst SHALL override iStart and abort a run in progress on the same edge.

Configuration
REQ-031 Macro CHECKER_MISR_EN defined: oSignature SHALL be a 32-bit MISR, polynomial 0x04C11DB7, each checked cycle: sig <= (sig<<1 ^ (sig[31]?poly:0)) ^ fold32({iCarry,iSum}), fold32 = XOR of 32-bit chunks (zero-padded).
REQ-032 Macro undefined: oSignature SHALL be constant 0 and no MISR logic synthesised.

Structure
REQ-033 Shared package adder_chk_pkg SHALL hold FSM state enum (IDLE, RUN, DONE), MISR polynomial constant, counter widths.
REQ-034 Alignment pipeline SHALL be sub-module chk_delay_line (parameters WIDTH, DEPTH).

Verification
REQ-035 Correct reference model, W=64, LAT=1, NUM_SAMPLES=4, 4 valids after iStart -> oDone at edge 6 after iStart, oErrCnt 0, oFirstErrIdx FFFFFFFF.
REQ-036 Inject sum bit0 flip on sample 2 only -> oErrFlag 1, oErrCnt 1, oFirstErrIdx 2.
REQ-037 A=B=all ones, C=1, DUT reports carry 0 -> mismatch counted (expected carry 1, sum all ones minus... i.e. 0xFFFF_FFFF_FFFF_FFFF).
REQ-038 NUM_SAMPLES=70000, every sample wrong -> oErrCnt saturates at FFFF, oFirstErrIdx 0.
REQ-039 iRst asserted mid-run after 2 samples -> next edge all outputs at reset values, state IDLE; later iStart re-runs cleanly.
REQ-040 CHECKER_MISR_EN set, A=1,B=0,C=0 single sample, NUM_SAMPLES=1 -> oSignature 32'h00000001; macro unset -> 0.
